sram_frame_reader: RTL and testbench
====================================

SRAM_FRAME_READER -- requirements
Module: sram_frame_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the SRAM address width (1024 bytes).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the SRAM and stream byte width.
REQ-003 SHALL have parameter READ_LATENCY, default 3, the number of edges from the SRAM read-port request edge to the edge where sram_dout1 is sampled.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the number of output buffer entries; it must be at least READ_LATENCY+1.
REQ-005 Port: clk  in  1  the single clock; all logic is on the rising edge.
REQ-006 Port: rst  in  1  synchronous, active-high reset.
REQ-007 Port: start  in  1  one-cycle request to read one frame.
REQ-008 Port: start_addr  in  ADDR_WIDTH  first byte address, sampled when start is accepted.
REQ-009 Port: length  in  ADDR_WIDTH+1  frame length in bytes (0..1024), sampled when start is accepted.
REQ-010 Port: busy  out  1  high from the accepted start until the done pulse.
REQ-011 Port: done  out  1  one-cycle pulse when the frame is complete.
REQ-012 Port: sram_csb1  out  1  SRAM read-port chip select, active-low.
REQ-013 Port: sram_addr1  out  ADDR_WIDTH  SRAM read-port address.
REQ-014 Port: sram_dout1  in  DATA_WIDTH  SRAM read-port data.
REQ-015 Port: m_data  out  DATA_WIDTH  output stream byte.
REQ-016 Port: m_valid  out  1  output byte valid.
REQ-017 Port: m_last  out  1  marks the final byte of the frame; qualified by m_valid.
REQ-018 Port: m_ready  in  1  sink accepts the byte when m_valid && m_ready.

Function
REQ-019 The FSM SHALL have three states: IDLE, READ and DRAIN.
REQ-020 In IDLE, start SHALL latch start_addr and length and go to READ.
  - If length==0: no SRAM read is issued, no stream byte is produced, done pulses on the next cycle, and the FSM stays in IDLE.
REQ-021 start while busy SHALL be ignored.
REQ-022 In READ, the block SHALL issue one read per cycle (sram_csb1=0, sram_addr1=current address) only while outstanding reads + FIFO occupancy < FIFO_DEPTH; otherwise sram_csb1=1.
REQ-023 Outstanding reads SHALL be tracked by a READ_LATENCY-deep valid shift register; the data for a request issued at edge k SHALL be pushed into the FIFO at edge k+READ_LATENCY.
REQ-024 The address SHALL increment by 1 per issued read and wrap modulo 2^ADDR_WIDTH (1023 -> 0).
REQ-025 When the issued count reaches length, the FSM SHALL go to DRAIN and hold sram_csb1=1.
REQ-026 In DRAIN, when the byte with m_last is accepted, done SHALL pulse in that same cycle and the FSM SHALL return to IDLE; busy SHALL drop in the following cycle.
REQ-027 The FIFO SHALL never overflow and SHALL preserve byte order.
REQ-028 m_valid = FIFO not empty; m_data/m_last = FIFO head; m_data and m_last SHALL remain stable while m_valid && !m_ready.
REQ-029 Push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-030 m_last SHALL be set only on the byte whose index equals length-1.
REQ-031 Peak throughput SHALL be 1 byte/cycle with m_ready held high.

Reset
REQ-032 rst SHALL force: FSM=IDLE, busy=0, done=0, sram_csb1=1, sram_addr1=0, m_valid=0, m_last=0, m_data=0, FIFO empty, and the outstanding pipeline cleared.
REQ-033 rst mid-frame SHALL abort the frame.
  - Reads still in flight SHALL be discarded and not pushed.
  - No done pulse SHALL be produced.
REQ-034 rst SHALL take priority over start.

Configuration
REQ-035 With macro SRAM_FRAME_READER_STALL_CNT_EN defined, the block SHALL add output port stall_cnt (16 bits).
  - Counts cycles with m_valid && !m_ready, saturating at 0xFFFF.
  - Cleared on rst and on each accepted start.
REQ-036 Without SRAM_FRAME_READER_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Frame at start_addr=0x010, length=5, m_ready=1, SRAM preloaded with 0xA0..0xA4: stream A0,A1,A2,A3,A4, m_last on A4, first m_valid 4 cycles after start, done with the A4 handshake.
REQ-038 Wrap case, start_addr=0x3FE, length=4: reads go to 0x3FE, 0x3FF, 0x000, 0x001 in that order, and the bytes come out in that order.
REQ-039 Backpressure, length=16, m_ready toggled 1/0 each cycle and then held low for 10 cycles: no byte lost or duplicated, outstanding reads + occupancy never exceed 4, and sram_csb1=1 while the FIFO is full.
REQ-040 length=0: done pulses one cycle after start, m_valid stays 0, sram_csb1 stays 1; a second start while busy during a length=8 frame is ignored (exactly 8 bytes out).
REQ-041 rst asserted 2 cycles after a length=10 start: all outputs take reset values next cycle, no done pulse; a new length=3 frame then completes correctly.
REQ-042 With SRAM_FRAME_READER_STALL_CNT_EN, length=4 with m_ready low for 7 cycles while m_valid=1: stall_cnt = 7, and stall_cnt clears on the next start.

Source files
------------

// File: rtl/sram_frame_reader.sv
// Streams a frame of bytes from a synchronous-read SRAM port into a ready/valid stream.
// Optional feature: define SRAM_FRAME_READER_STALL_CNT_EN to add the 16-bit stall_cnt output.
module sram_frame_reader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
`ifdef SRAM_FRAME_READER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [PW-1:0]         PTR_LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     issued_q;
    logic [ADDR_WIDTH-1:0]   next_addr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    csb_q;
    logic                    busy_q;
    logic                    done_zero_q;
    logic [READ_LATENCY-1:0] pipe_q;
    logic [READ_LATENCY-1:0] pipe_d;
    logic [READ_LATENCY-1:0] last_pipe_q;
    logic [READ_LATENCY-1:0] last_pipe_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic                    fifo_last_q [FIFO_DEPTH];
    logic [PW-1:0]           rd_q;
    logic [PW-1:0]           wr_q;
    logic [CNTW-1:0]         count_q;
    logic [CNTW-1:0]         count_d;
    logic [CW-1:0]           inflight;
    logic                    push;
    logic                    pop;
    logic                    can_issue;
    logic                    issue_last;
    logic                    frame_done;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // A new read is allowed only if every committed byte (in flight or buffered,
    // less the one leaving this cycle) still has a FIFO slot once it lands.
    always_comb begin
        pop      = (count_q != '0) && m_ready;
        push     = pipe_q[READ_LATENCY-1];
        inflight = CW'(count_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_q[i]);
        end
        can_issue   = (state_q == READ) && (issued_q < len_q) &&
                      ((inflight - CW'(pop)) < CW'(FIFO_DEPTH));
        issue_last  = (issued_q == len_q - LEN_ONE);
        frame_done  = (state_q == DRAIN) && pop && m_last;
        pipe_d      = pipe_q << 1;
        pipe_d[0]   = can_issue;
        last_pipe_d = last_pipe_q << 1;
        last_pipe_d[0] = can_issue && issue_last;
        count_d     = count_q + CNTW'(push) - CNTW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            next_addr_q <= '0;
            addr_q      <= '0;
            csb_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_zero_q <= 1'b0;
            pipe_q      <= '0;
            last_pipe_q <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
        end else begin
            pipe_q      <= pipe_d;
            last_pipe_q <= last_pipe_d;
            csb_q       <= !can_issue;
            done_zero_q <= 1'b0;
            count_q     <= count_d;
            if (push) begin
                wr_q <= ptr_inc(wr_q);
            end
            if (pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            if (can_issue) begin
                addr_q      <= next_addr_q;
                next_addr_q <= next_addr_q + ADDR_ONE;
                issued_q    <= issued_q + LEN_ONE;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q       <= length;
                        next_addr_q <= start_addr;
                        issued_q    <= '0;
                        if (length == '0) begin
                            done_zero_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (can_issue && issue_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (frame_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_q] <= sram_dout1;
            fifo_last_q[wr_q] <= last_pipe_q[READ_LATENCY-1];
        end
    end

    assign busy       = busy_q;
    assign done       = done_zero_q || frame_done;
    assign sram_csb1  = csb_q;
    assign sram_addr1 = addr_q;
    assign m_valid    = (count_q != '0);
    assign m_data     = m_valid ? fifo_data_q[rd_q] : '0;
    assign m_last     = m_valid && fifo_last_q[rd_q];

`ifdef SRAM_FRAME_READER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_q <= '0;
        end else if (m_valid && !m_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sram_frame_reader.sv
// Self-checking bench for sram_frame_reader: table-driven frames, directed corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_sram_frame_reader;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int RL = 3;
    localparam int FD = 4;

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   len_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    addr_t         start_addr = '0;
    len_t          length = '0;
    logic          busy;
    logic          done;
    logic          sram_csb1;
    addr_t         sram_addr1;
    logic [DW-1:0] sram_dout1;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
`ifdef SRAM_FRAME_READER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    sram_frame_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
        .sram_dout1(sram_dout1), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready)
`ifdef SRAM_FRAME_READER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // SRAM model: request registered by the DUT at edge k, data sampled at edge k+RL.
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] rdPipe [0:RL-2];

    always @(posedge clk) begin
        rdPipe[0] <= sram_csb1 ? DW'($urandom) : mem[sram_addr1];
        for (int i = 1; i < RL - 1; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign sram_dout1 = rdPipe[RL-2];

    typedef struct { logic [DW-1:0] data; logic last; } byte_t;
    typedef struct {
        addr_t addr; len_t len; int mode; int expBytes; addr_t expLastAddr;
    } vec_t;

    byte_t     dataQ [$];
    addr_t     addrQ [$];
    int        checks = 0;
    int        failures = 0;
    bit        modelBusy = 0;
    bit        len0Pending = 0;
    bit        justReset = 0;
    bit        prevStall = 0;
    logic [DW-1:0] prevData;
    logic      prevLast;
    int        issuedTotal = 0;
    int        acceptedTotal = 0;
    int        frameBytes = 0;
    addr_t     lastReadAddr = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit readyFor(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return $urandom_range(0, 3) == 0;
        endcase
    endfunction

    // One clock cycle: drive inputs after the falling edge, then check outputs and
    // advance the frame-level model for the coming rising edge.
    task automatic applyStimulus(input bit st, input addr_t sa, input len_t ln, input bit rdy, input bit rs);
        bit    busyNow;
        bit    expDone;
        bit    frameEnd;
        byte_t b;
        @(negedge clk);
        rst = rs; start = st; start_addr = sa; length = ln; m_ready = rdy;
        #1;
        if (rs) begin
            dataQ.delete(); addrQ.delete();
            modelBusy = 0; len0Pending = 0; prevStall = 0; justReset = 1;
            issuedTotal = 0; acceptedTotal = 0;
            return;
        end
        if (justReset) begin
            checkOutput("reset_busy", busy, 0);
            checkOutput("reset_done", done, 0);
            checkOutput("reset_csb", sram_csb1, 1);
            checkOutput("reset_addr", sram_addr1, 0);
            checkOutput("reset_valid", m_valid, 0);
            checkOutput("reset_last", m_last, 0);
            checkOutput("reset_data", m_data, 0);
            justReset = 0;
        end
        busyNow  = modelBusy;
        frameEnd = 0;
        checkOutput("busy", busy, busyNow);
        if (!sram_csb1) begin
            checkOutput("read_expected", addrQ.size() != 0, 1);
            if (addrQ.size() != 0) checkOutput("read_addr", sram_addr1, addrQ.pop_front());
            lastReadAddr = sram_addr1;
            issuedTotal++;
        end
        checkOutput("committed_le_depth", (issuedTotal - acceptedTotal) <= FD, 1);
        if (prevStall) begin
            checkOutput("hold_valid", m_valid, 1);
            checkOutput("hold_data", m_data, prevData);
            checkOutput("hold_last", m_last, prevLast);
        end
        expDone = len0Pending;
        if (m_valid) begin
            checkOutput("byte_expected", dataQ.size() != 0, 1);
            if (m_ready && dataQ.size() != 0) begin
                b = dataQ.pop_front();
                checkOutput("m_data", m_data, b.data);
                checkOutput("m_last", m_last, b.last);
                if (b.last) begin
                    expDone  = 1;
                    frameEnd = 1;
                end
                acceptedTotal++;
                frameBytes++;
            end
        end
        checkOutput("done", done, expDone);
        len0Pending = 0;
        if (frameEnd) modelBusy = 0;
        prevStall = m_valid && !m_ready;
        prevData  = m_data;
        prevLast  = m_last;
        if (st && !busyNow) begin
            frameBytes = 0;
            if (ln == 0) begin
                len0Pending = 1;
            end else begin
                modelBusy = 1;
                for (int i = 0; i < int'(ln); i++) begin
                    addrQ.push_back(addr_t'(int'(sa) + i));
                    dataQ.push_back('{mem[addr_t'(int'(sa) + i)], (i == int'(ln) - 1)});
                end
            end
        end
    endtask

    task automatic drain(input int mode, input int bound, input bit extraStarts);
        bit finished = 0;
        for (int c = 0; c < bound; c++) begin
            if (!modelBusy && !len0Pending && dataQ.size() == 0) begin
                finished = 1;
                break;
            end
            if (extraStarts && $urandom_range(0, 7) == 0)
                applyStimulus(1, addr_t'($urandom), len_t'($urandom_range(0, 20)), readyFor(mode, c), 0);
            else
                applyStimulus(0, '0, '0, readyFor(mode, c), 0);
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("[TB] FAIL frame_timeout: frame still open after %0d cycles", bound);
        end
    endtask

    task automatic runFrame(input addr_t sa, input len_t ln, input int mode);
        applyStimulus(1, sa, ln, readyFor(mode, 0), 0);
        drain(mode, int'(ln) * 8 + 40, 0);
    endtask

    vec_t vecs [7];

    initial begin
        bit seen;
        vecs[0] = '{10'h010, 11'd5,    0, 5,    10'h014};
        vecs[1] = '{10'h3FE, 11'd4,    0, 4,    10'h001};
        vecs[2] = '{10'h3FF, 11'd1,    1, 1,    10'h3FF};
        vecs[3] = '{10'h000, 11'd0,    0, 0,    10'h000};
        vecs[4] = '{10'h123, 11'd16,   2, 16,   10'h132};
        vecs[5] = '{10'h3F0, 11'd32,   3, 32,   10'h00F};
        vecs[6] = '{10'h200, 11'd1024, 0, 1024, 10'h1FF};

        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 5; i++) mem[16 + i] = DW'(8'hA0 + i);

        applyStimulus(0, '0, '0, 0, 1);
        applyStimulus(0, '0, '0, 0, 1);

        // First byte latency on the A0..A4 frame.
        applyStimulus(1, 10'h010, 11'd5, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, '0, '0, 1, 0);
            checkOutput("first_valid_early", m_valid, 0);
        end
        applyStimulus(0, '0, '0, 1, 0);
        checkOutput("first_valid", m_valid, 1);
        checkOutput("first_data", m_data, 8'hA0);
        drain(0, 40, 0);
        checkOutput("a0_frame_bytes", frameBytes, 5);

        foreach (vecs[i]) begin
            runFrame(vecs[i].addr, vecs[i].len, vecs[i].mode);
            checkOutput("vec_bytes", frameBytes, vecs[i].expBytes);
            if (vecs[i].len != 0) checkOutput("vec_last_addr", lastReadAddr, vecs[i].expLastAddr);
        end

        // Backpressure: toggling ready, then held low with the buffer full.
        applyStimulus(1, 10'h080, 11'd16, 1, 0);
        for (int c = 0; c < 12; c++) applyStimulus(0, '0, '0, (c % 2) == 1, 0);
        for (int c = 0; c < 10; c++) applyStimulus(0, '0, '0, 0, 0);
        drain(0, 100, 0);
        checkOutput("bp_frame_bytes", frameBytes, 16);

        // Zero-length frame, then a start ignored while busy.
        applyStimulus(1, 10'h050, 11'd0, 1, 0);
        applyStimulus(0, '0, '0, 1, 0);
        checkOutput("len0_done", done, 1);
        checkOutput("len0_valid", m_valid, 0);
        applyStimulus(0, '0, '0, 1, 0);
        checkOutput("len0_done_once", done, 0);
        applyStimulus(1, 10'h060, 11'd8, 1, 0);
        applyStimulus(0, '0, '0, 1, 0);
        applyStimulus(1, 10'h070, 11'd8, 1, 0);
        drain(0, 100, 0);
        checkOutput("busy_start_bytes", frameBytes, 8);

        // Reset two cycles into a frame, then a clean frame.
        applyStimulus(1, 10'h100, 11'd10, 1, 0);
        applyStimulus(0, '0, '0, 1, 0);
        applyStimulus(0, '0, '0, 1, 1);
        applyStimulus(0, '0, '0, 1, 0);
        for (int c = 0; c < 8; c++) applyStimulus(0, '0, '0, 1, 0);
        runFrame(10'h105, 11'd3, 0);
        checkOutput("post_reset_bytes", frameBytes, 3);

`ifdef SRAM_FRAME_READER_STALL_CNT_EN
        applyStimulus(1, 10'h020, 11'd4, 0, 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, '0, '0, 0, 0);
            if (m_valid) begin
                seen = 1;
                break;
            end
        end
        checkOutput("stall_valid_seen", seen, 1);
        for (int k = 0; k < 6; k++) applyStimulus(0, '0, '0, 0, 0);
        drain(0, 40, 0);
        checkOutput("stall_cnt", stall_cnt, 7);
        applyStimulus(1, 10'h030, 11'd2, 1, 0);
        applyStimulus(0, '0, '0, 1, 0);
        checkOutput("stall_cnt_clear", stall_cnt, 0);
        drain(0, 40, 0);
`else
        seen = 0;
`endif

        for (int f = 0; f < 25; f++) begin
            applyStimulus(1, addr_t'($urandom), len_t'($urandom_range(0, 40)), 1, 0);
            drain($urandom_range(0, 3), 2000, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
